// File: rtl/icache_mem_responder.sv
// Fixed-latency line-fill responder for the instruction cache, backed by a preloadable line store.
// Define ICACHE_MEMRSP_REQ_QUEUE_EN to add a 2-entry request FIFO in front of the FSM.
module icache_mem_responder #(
  parameter int unsigned LATENCY       = 4,
  parameter int unsigned LINE_IDX_BITS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              i_mem_addr,
  input  logic                     i_mem_req_valid,
  output logic                     o_mem_ready,
  output logic [127:0]             o_mem_data,
  output logic                     o_mem_data_valid,
  input  logic                     i_halt,
  input  logic                     i_wr_en,
  input  logic [LINE_IDX_BITS-1:0] i_wr_idx,
  input  logic [127:0]             i_wr_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]               state_q;
  logic [3:0]               cnt_q;
  logic [LINE_IDX_BITS-1:0] idx_q;
  logic [127:0]             data_q;
  logic [127:0]             mem [2**LINE_IDX_BITS];

  logic [LINE_IDX_BITS-1:0] req_idx;
  logic [LINE_IDX_BITS-1:0] start_idx;
  logic                     take;
  logic                     start;
  logic                     unused_addr;

  assign req_idx     = i_mem_addr[4 +: LINE_IDX_BITS];
  // Offset and high address bits alias onto the same line.
  assign unused_addr = ^{i_mem_addr[15:4+LINE_IDX_BITS], i_mem_addr[3:0]};

`ifdef ICACHE_MEMRSP_REQ_QUEUE_EN
  logic [LINE_IDX_BITS-1:0] fifo_q [2];
  logic                     rd_ptr_q;
  logic                     wr_ptr_q;
  logic [1:0]               fifo_cnt_q;
  logic                     leaving;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     bypass;

  always_comb begin
    fifo_empty  = (fifo_cnt_q == 2'd0);
    o_mem_ready = !rst && !i_halt && (fifo_cnt_q != 2'd2);
    leaving     = !i_halt && ((state_q == IDLE) || (state_q == RESP));
    take        = i_mem_req_valid && o_mem_ready;
    // An empty FIFO with the FSM free hands the request straight through.
    bypass      = take && leaving && fifo_empty;
    push        = take && !bypass;
    pop         = leaving && !fifo_empty;
    start       = pop || bypass;
    start_idx   = pop ? fifo_q[rd_ptr_q] : req_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= req_idx;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
`else
  always_comb begin
    o_mem_ready = !rst && !i_halt && ((state_q == IDLE) || (state_q == RESP));
    take        = i_mem_req_valid && o_mem_ready;
    start       = take;
    start_idx   = req_idx;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      data_q  <= '0;
    end else if (!i_halt) begin
      case (state_q)
        IDLE, RESP: begin
          if (start) begin
            state_q <= COUNT;
            cnt_q   <= 4'(LATENCY - 1);
            idx_q   <= start_idx;
          end else begin
            state_q <= IDLE;
          end
        end
        COUNT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            data_q  <= mem[idx_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Preload stays live through halt and reset; a same-edge capture sees the old line.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_mem_data       = data_q;
  assign o_mem_data_valid = (state_q == RESP);

endmodule
